// File: rtl/pc_fetch.sv
// Purpose : fetch stage; owns the PC, issues in-order imem requests, buffers responses for IF/ID.
// Latency : grant at G, response at R >= G+1, instruction on inst/pc_addr at R+2 (no bypass).
// Backpres: full_stall freezes the outputs; requests continue until DEPTH credits are used up.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   jump_en, jump_addr       redirect (priority over full_stall); flushes the queued stream
//   full_stall               hold output registers
//   imem_req/addr/gnt        request channel; imem_addr is the PC register
//   imem_rvalid/rdata        in-order responses
//   inst, pc_addr            instruction and its PC, both zero when inst_valid is low
//   inst_valid               output registers hold a live instruction
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   input  logic        full_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc_addr,
   output logic        inst_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_U = (CW + 1)'(DEPTH);

   logic [31:0]   pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] iq_count;
   logic [AW-1:0] tq_wr, tq_rd;
   logic [AW-1:0] iq_wr, iq_rd;

   logic [31:0] tag_mem [DEPTH];
   logic [31:0] iq_pc   [DEPTH];
   logic [31:0] iq_inst [DEPTH];

   logic [CW:0] used;
   logic        grant;
   logic        resp_keep;
   logic        iq_pop;

   // A credit covers a request from grant until its entry leaves the queue,
   // so the instruction queue can never be pushed while full.
   assign used      = {1'b0, outstanding} + {1'b0, iq_count};
   assign imem_req  = !jump_en && (used < DEPTH_U);
   assign imem_addr = pc;
   assign grant     = imem_req && imem_gnt;
   // A response arriving in a jump cycle belongs to the old stream and is dropped.
   assign resp_keep = imem_rvalid && !jump_en && (discard == '0);
   // No bypass: only entries already queued at the start of the cycle can pop.
   assign iq_pop    = !jump_en && !full_stall && (iq_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         tq_wr       <= '0;
         tq_rd       <= '0;
      end else begin
         if (jump_en)
            pc <= jump_addr;
         else if (grant)
            pc <= pc + 32'd4;

         case ({grant, imem_rvalid})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: ;
         endcase

         if (grant)
            tq_wr <= tq_wr + AW'(1);
         // Tags are popped even for discarded responses so later ones stay aligned.
         if (imem_rvalid)
            tq_rd <= tq_rd + AW'(1);

         // Every request still in flight after this cycle belongs to the old stream.
         if (jump_en)
            discard <= outstanding - CW'(imem_rvalid);
         else if (imem_rvalid && (discard != '0))
            discard <= discard - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iq_count <= '0;
         iq_wr    <= '0;
         iq_rd    <= '0;
      end else if (jump_en) begin
         iq_count <= '0;
         iq_rd    <= iq_wr;
      end else begin
         if (resp_keep)
            iq_wr <= iq_wr + AW'(1);
         if (iq_pop)
            iq_rd <= iq_rd + AW'(1);
         if (resp_keep && !iq_pop)
            iq_count <= iq_count + CW'(1);
         else if (!resp_keep && iq_pop)
            iq_count <= iq_count - CW'(1);
      end
   end

   // Storage needs no reset: pointers and counts define what is live.
   always_ff @(posedge clk) begin
      if (grant)
         tag_mem[tq_wr] <= pc;
      if (resp_keep) begin
         iq_pc[iq_wr]   <= tag_mem[tq_rd];
         iq_inst[iq_wr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst       <= '0;
         pc_addr    <= '0;
         inst_valid <= 1'b0;
      end else if (jump_en) begin
         inst       <= '0;
         pc_addr    <= '0;
         inst_valid <= 1'b0;
      end else if (!full_stall) begin
         if (iq_count != '0) begin
            inst       <= iq_inst[iq_rd];
            pc_addr    <= iq_pc[iq_rd];
            inst_valid <= 1'b1;
         end else begin
            inst       <= '0;
            pc_addr    <= '0;
            inst_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
`timescale 1ns/1ps
module tb_pc_fetch;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        full_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc_addr;
   logic        inst_valid;

   always #5 clk = ~clk;

   pc_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr),
      .full_stall(full_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst(inst), .pc_addr(pc_addr), .inst_valid(inst_valid)
   );

   // Reference model: each in-flight request carries the stream epoch it was
   // issued in; a jump starts a new epoch, and only current-epoch responses
   // become instructions.
   typedef struct { logic [31:0] pc; int epoch; } infl_t;
   typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   infl_t       m_infl[$];
   ent_t        m_iq[$];
   mreq_t       mq[$];
   logic [31:0] m_pc, m_inst, m_pcaddr;
   logic        m_valid;
   int          m_epoch;

   int          cyc;
   int          lat_min, lat_max;
   int          errors, checks;
   logic        req_seen;
   logic [31:0] addr_seen;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic wait_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s cycle=%0d got=no valid output expected=valid output within bound", name, cyc);
   endtask

   task automatic model_reset();
      m_pc = RPC;
      m_infl.delete();
      m_iq.delete();
      m_inst = '0;
      m_pcaddr = '0;
      m_valid = 1'b0;
      m_epoch = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      jump_en = 1'b0;
      jump_addr = '0;
      full_stall = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      mq.delete();
      model_reset();
      @(negedge clk);
      check("rst_inst", inst, 32'h0);
      check("rst_pc_addr", pc_addr, 32'h0);
      check1("rst_inst_valid", inst_valid, 1'b0);
      check("rst_imem_addr", imem_addr, 32'h0000_0100);
      check1("rst_imem_req", imem_req, 1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock cycle: drive at negedge, check request side, advance model at
   // posedge, check registered outputs at the following negedge.
   task automatic tick(input logic jmp, input logic [31:0] ja, input logic stall, input logic gnt);
      logic  m_req, g, rv, t_ok;
      infl_t t;
      ent_t  e;
      jump_en = jmp;
      jump_addr = ja;
      full_stall = stall;
      imem_gnt = gnt;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata = mem_word(mq[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata = $urandom;
      end
      #1;
      m_req = !jmp && (m_infl.size() + m_iq.size() < DEPTH);
      req_seen = imem_req;
      addr_seen = imem_addr;
      check1("imem_req", imem_req, m_req);
      check("imem_addr", imem_addr, m_pc);
      rv = imem_rvalid;
      g = m_req && gnt;
      @(posedge clk);
      // memory
      if (rv) void'(mq.pop_front());
      if (req_seen && gnt)
         mq.push_back('{addr_seen, cyc + int'($urandom_range(lat_max, lat_min))});
      // model
      t_ok = 1'b0;
      t = '{32'h0, -1};
      if (rv) begin
         if (m_infl.size() > 0) begin
            t = m_infl.pop_front();
            t_ok = 1'b1;
         end else begin
            check1("response_without_request", 1'b1, 1'b0);
         end
      end
      if (jmp) begin
         m_iq.delete();
         m_inst = '0;
         m_pcaddr = '0;
         m_valid = 1'b0;
         m_epoch++;
         m_pc = ja;
      end else begin
         if (!stall) begin
            if (m_iq.size() > 0) begin
               e = m_iq.pop_front();
               m_inst = e.word;
               m_pcaddr = e.pc;
               m_valid = 1'b1;
            end else begin
               m_inst = '0;
               m_pcaddr = '0;
               m_valid = 1'b0;
            end
         end
         if (t_ok && t.epoch == m_epoch)
            m_iq.push_back('{t.pc, mem_word(t.pc)});
         if (g) begin
            m_infl.push_back('{m_pc, m_epoch});
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      @(negedge clk);
      check("inst", inst, m_inst);
      check("pc_addr", pc_addr, m_pcaddr);
      check1("inst_valid", inst_valid, m_valid);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d got=still running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        found;
      int          jleft;
      logic [31:0] ja;
      errors = 0;
      checks = 0;
      cyc = 0;
      lat_min = 1;
      lat_max = 1;
      do_reset();

      // Stream start with 1-cycle memory
      tick(0, 0, 0, 1);
      check("s1_addr0", addr_seen, 32'h0000_0100);
      tick(0, 0, 0, 1);
      check("s1_addr1", addr_seen, 32'h0000_0104);
      check1("s1_valid_g2", inst_valid, 1'b0);
      tick(0, 0, 0, 1);
      check("s1_addr2", addr_seen, 32'h0000_0108);
      check1("s1_valid_g3", inst_valid, 1'b1);
      check("s1_first_pc", pc_addr, 32'h0000_0100);
      check("s1_first_inst", inst, mem_word(32'h0000_0100));
      repeat (4) tick(0, 0, 0, 1);

      // Stall for 6 cycles: credits run out, then stream resumes
      for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
      check1("s2_req_dropped", req_seen, 1'b0);
      repeat (8) tick(0, 0, 0, 1);

      // Jump with 2 requests in flight at 3-cycle latency
      do_reset();
      lat_min = 3;
      lat_max = 3;
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      repeat (3) tick(0, 0, 0, 0);
      tick(0, 0, 1, 1);
      tick(0, 0, 1, 1);
      check1("s3_valid_before", inst_valid, 1'b1);
      check("s3_pc_before", pc_addr, 32'h0000_0100);
      tick(1, 32'h0000_0200, 0, 1);
      check1("s3_valid_jump", inst_valid, 1'b0);
      check("s3_pc_jump", pc_addr, 32'h0);
      check("s3_inst_jump", inst, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(0, 0, 0, 1);
         if (inst_valid === 1'b1) begin
            found = 1'b1;
            check("s3_first_pc", pc_addr, 32'h0000_0200);
            check("s3_first_inst", inst, mem_word(32'h0000_0200));
         end
      end
      if (!found) wait_fail("s3_wait_valid");

      // Jump coinciding with a response and full_stall, 2-cycle memory
      do_reset();
      lat_min = 2;
      lat_max = 2;
      repeat (8) tick(0, 0, 0, 1);
      check1("s4_valid_before", inst_valid, 1'b1);
      tick(1, 32'h0000_0300, 1, 1);
      check1("s4_valid_jump", inst_valid, 1'b0);
      check("s4_pc_jump", pc_addr, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(0, 0, 0, 1);
         if (inst_valid === 1'b1) begin
            found = 1'b1;
            check("s4_first_pc", pc_addr, 32'h0000_0300);
         end
      end
      if (!found) wait_fail("s4_wait_valid");

      // Redirect latency and PC wrap with 1-cycle memory
      do_reset();
      lat_min = 1;
      lat_max = 1;
      repeat (3) tick(0, 0, 0, 1);
      tick(1, 32'hFFFF_FFFC, 0, 1);
      check1("s5_req_in_jump", req_seen, 1'b0);
      tick(0, 0, 0, 1);
      check("s5_target_req", addr_seen, 32'hFFFF_FFFC);
      tick(0, 0, 0, 1);
      check("s5_wrap_addr", addr_seen, 32'h0000_0000);
      check1("s5_valid_j3", inst_valid, 1'b0);
      tick(0, 0, 0, 1);
      check1("s5_valid_j4", inst_valid, 1'b1);
      check("s5_pc_j4", pc_addr, 32'hFFFF_FFFC);
      repeat (3) tick(0, 0, 0, 1);

      // Grant withheld for 5 cycles
      do_reset();
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 0, 0);
         check("s6_addr_hold", addr_seen, 32'h0000_0108);
      end
      check1("s6_bubble_valid", inst_valid, 1'b0);
      check("s6_bubble_inst", inst, 32'h0);
      tick(0, 0, 0, 1);
      check("s6_resume_addr", addr_seen, 32'h0000_0108);
      repeat (4) tick(0, 0, 0, 1);

      // Randomized traffic: variable latency, stalls, held jumps, resets
      do_reset();
      lat_min = 1;
      lat_max = 4;
      jleft = 0;
      ja = '0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(999) == 0) do_reset();
         if (jleft == 0 && $urandom_range(99) < 3) begin
            jleft = int'($urandom_range(3, 1));
            ja = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            ja[1:0] = 2'b00;
         end
         tick(jleft > 0, ja, $urandom_range(99) < 20, $urandom_range(99) < 75);
         if (jleft > 0) jleft--;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Fetch stage directly upstream of the IF/ID pipeline register. Holds the program counter and issues in-order instruction-memory requests with a credit-limited prefetch queue. Presents one instruction and its PC per cycle to IF/ID. On a jump it redirects the PC, flushes the queue and discards in-flight responses from the old stream.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 4, prefetch credits: max (in-flight requests + queued entries); power of two, 2..8
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- jump_en  in  1  redirect request; one-cycle pulse or held
- jump_addr  in  32  redirect target, word-aligned
- full_stall  in  1  downstream hold; output registers keep their value
- imem_req  out  1  request valid (combinational)
- imem_addr  out  32  request address, equal to PC register
- imem_gnt  in  1  request accepted this cycle; only meaningful when imem_req=1
- imem_rvalid  in  1  response valid; responses in request order, latency >= 1 cycle
- imem_rdata  in  32  response instruction word
- inst  out  32  instruction to IF/ID; 0 (NOP) when not valid
- pc_addr  out  32  PC of inst; 0 when not valid
- inst_valid  out  1  inst/pc_addr hold a live instruction

## Operation
- State:
  - pc register
  - outstanding counter (0..DEPTH)
  - discard counter (0..DEPTH)
  - PC-tag queue, DEPTH entries, holding the PC of each in-flight request
  - instruction queue, DEPTH entries of {pc, inst}
  - output registers
- imem_req = !jump_en && (outstanding + iq_count < DEPTH).
- On imem_gnt: push pc into the tag queue, outstanding++, pc <= pc + 4 (32-bit wrap, no flag).
- On imem_rvalid: pop the tag queue, outstanding--.
  - If discard > 0: drop the response, discard--.
  - Otherwise: push {tag, imem_rdata} into the instruction queue.
- Output update when !full_stall and !jump_en:
  - queue non-empty: pop the head into inst/pc_addr, inst_valid <= 1.
  - queue empty: inst <= 0, pc_addr <= 0, inst_valid <= 0.
- full_stall=1 and jump_en=0: output registers hold. Queues keep filling until credits run out.
- jump_en=1 (priority over full_stall):
  - pc <= jump_addr.
  - Instruction queue cleared.
  - Output registers <= 0 / 0 / 0.
  - discard <= outstanding - imem_rvalid. An rvalid in the jump cycle is itself dropped.
  - Tag-queue entries are retained so later discarded responses still pop correctly.
- jump_en held for several cycles: each cycle reloads pc and recomputes discard. No requests are issued while jump_en is high.
- Simultaneous gnt and rvalid: both counters update, net outstanding unchanged.
- Simultaneous pop and push on the instruction queue: both occur; iq_count unchanged.
- Credits guarantee the instruction queue never overflows. No push is ever refused.

## Timing
- Reset (async assert):
  - pc = RESET_PC
  - outstanding = discard = 0
  - queues empty
  - inst = pc_addr = 0, inst_valid = 0
  - imem_req is 1 in the first cycle after deassert
- Latency from grant to output, with no stall and no bypass:
  - grant at cycle G, rvalid at R >= G+1.
  - Entry is in the queue at R+1, popped at the end of R+1, and inst_valid=1 at R+2.
- Redirect latency:
  - jump at cycle J: imem_req=0 in J.
  - Request to jump_addr at J+1.
  - With 1-cycle memory, the target instruction appears on the outputs at J+4.
- Throughput: one instruction per cycle sustained with 1-cycle memory and DEPTH >= 4.
- Reset mid-operation: all state is cleared immediately. Responses for pre-reset requests must not arrive after reset; the memory is reset by the same rst.

## Test plan
- Reset release, RESET_PC=0x100, 1-cycle memory always granting -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; inst_valid first 1 three cycles after the first grant, pc_addr=0x100.
- full_stall held for 6 cycles in steady stream -> outputs frozen; imem_req drops once outstanding + iq_count = 4; after release, pc_addr continues with no gaps and no duplicates.
- jump_en pulse to 0x200 with 2 requests in flight at 3-cycle latency -> outputs zeroed that cycle; the next 2 responses are dropped; the first valid output has pc_addr=0x200.
- jump_en in the same cycle as imem_rvalid and full_stall -> that response is dropped, outputs are zero, and discard = outstanding - 1.
- imem_gnt deasserted for 5 cycles -> imem_addr is stable during the wait; no PC skip; inst_valid=0 bubbles emit inst=0.
- pc=0xFFFF_FFFC granted -> next imem_addr is 0x0000_0000.
